// File: rtl/fc_pkg.sv
// Shared types and helpers for the dense-layer engine: FSM states,
// accumulator sizing and the fixed-point shift/saturate step.
package fc_pkg;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_OUT} fc_state_t;

  // Wide enough to hold any accumulator before narrowing to DATA_W.
  localparam int WIDE_W = 128;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Sum of IN_LEN full-width products plus a shifted bias cannot overflow this.
  function automatic int acc_width(input int data_w, input int in_len);
    return 2*data_w + $clog2(in_len) + 1;
  endfunction

  function automatic wide_t shift_sat(input wide_t acc, input int frac_w, input int data_w);
    wide_t sh, hi, lo;
    sh = acc >>> frac_w;
    hi = (wide_t'(1) <<< (data_w-1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (data_w-1));
    if (sh > hi) return hi;
    if (sh < lo) return lo;
    return sh;
  endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// One output channel: bias register, product register, accumulator and
// result register. Optional ReLU on the result when FC_RELU_EN is defined.
module fc_mac_lane
  import fc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 38
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bias_we,
  input  logic [DATA_W-1:0]        bias_wdata,
  input  logic                     acc_init,
  input  logic                     prod_en,
  input  logic                     acc_en,
  input  logic                     res_en,
  input  logic signed [DATA_W-1:0] act,
  input  logic signed [DATA_W-1:0] weight,
  output logic [DATA_W-1:0]        res
);

  localparam int PW = 2*DATA_W;

  logic signed [DATA_W-1:0] bias;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc;
  wide_t                    res_wide;
  logic [WIDE_W-DATA_W-1:0] unused_hi;
  logic [DATA_W-1:0]        res_next;

  assign res_wide  = shift_sat(wide_t'(acc), FRAC_W, DATA_W);
  assign unused_hi = res_wide[WIDE_W-1:DATA_W];

`ifdef FC_RELU_EN
  assign res_next = res_wide[DATA_W-1] ? '0 : res_wide[DATA_W-1:0];
`else
  assign res_next = res_wide[DATA_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bias <= '0;
      prod <= '0;
      acc  <= '0;
      res  <= '0;
    end else begin
      if (bias_we) bias <= bias_wdata;
      if (prod_en) prod <= PW'(act) * PW'(weight);
      // Bias enters the accumulator already aligned to the product's fraction.
      if (acc_init)    acc <= ACC_W'(bias) <<< FRAC_W;
      else if (acc_en) acc <= acc + ACC_W'(prod);
      if (res_en) res <= res_next;
    end
  end

endmodule

// File: rtl/fc_layer_engine.sv
// Dense-layer engine: bias bank load, per-frame MAC over IN_LEN beats on
// OUT_CH lanes, saturated result handshake. FC_RELU_EN fuses a ReLU.
module fc_layer_engine
  import fc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int IN_LEN = 25,
  parameter int OUT_CH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     bias_valid,
  input  logic [DATA_W-1:0]        bias_data,
  output logic                     bias_ready,
  output logic                     bias_loaded,
  input  logic                     start,
  output logic                     busy,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [OUT_CH*DATA_W-1:0] in_weight,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [OUT_CH*DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     done
);

  localparam int ACC_W = acc_width(DATA_W, IN_LEN);
  localparam int CNT_W = $clog2(IN_LEN+1);
  localparam int PTR_W = (OUT_CH > 1) ? $clog2(OUT_CH) : 1;

  fc_state_t        state;
  logic [CNT_W-1:0] beat_cnt;
  logic [PTR_W-1:0] wptr, wptr_eff;
  logic             prod_vld;
  logic             bias_fire, start_fire, in_fire, out_fire, res_en;

  assign bias_ready = (state == S_IDLE) && !start;
  assign bias_fire  = bias_valid && bias_ready;
  assign start_fire = (state == S_IDLE) && start && bias_loaded;
  assign in_ready   = (state == S_RUN) && (beat_cnt < CNT_W'(IN_LEN));
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign busy       = (state != S_IDLE);
  // The last product has landed once no product is pending in DRAIN.
  assign res_en     = (state == S_DRAIN) && !prod_vld;
  // A word offered to a complete bank restarts the fill at channel 0.
  assign wptr_eff   = bias_loaded ? '0 : wptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr        <= '0;
      bias_loaded <= 1'b0;
    end else if (bias_fire) begin
      if (wptr_eff == PTR_W'(OUT_CH-1)) begin
        wptr        <= '0;
        bias_loaded <= 1'b1;
      end else begin
        wptr        <= wptr_eff + PTR_W'(1);
        bias_loaded <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      prod_vld  <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      prod_vld <= in_fire;
      done     <= 1'b0;
      case (state)
        S_IDLE: if (start_fire) begin
          state    <= S_RUN;
          beat_cnt <= '0;
        end
        S_RUN: if (in_fire) begin
          beat_cnt <= beat_cnt + CNT_W'(1);
          if (beat_cnt == CNT_W'(IN_LEN-1)) state <= S_DRAIN;
        end
        S_DRAIN: if (res_en) begin
          state     <= S_OUT;
          out_valid <= 1'b1;
        end
        S_OUT: if (out_fire) begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          done      <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar c = 0; c < OUT_CH; c++) begin : g_lane
    fc_mac_lane #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W)) u_lane (
      .clk       (clk),
      .rst       (rst),
      .bias_we   (bias_fire && (wptr_eff == PTR_W'(c))),
      .bias_wdata(bias_data),
      .acc_init  (start_fire),
      .prod_en   (in_fire),
      .acc_en    (prod_vld),
      .res_en    (res_en),
      .act       (in_data),
      .weight    (in_weight[c*DATA_W +: DATA_W]),
      .res       (out_data[c*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Self-checking bench for fc_layer_engine (2 lanes, 4 beats): directed table,
// hand-written reset/bias corner cases and random frames against a model.
module tb_fc_layer_engine;

  localparam int DW = 16, FW = 8, IL = 4, OC = 2;

  logic              clk = 1'b0, rst = 1'b0;
  logic              bias_valid, bias_ready, bias_loaded, start, busy;
  logic [DW-1:0]     bias_data, in_data;
  logic [OC*DW-1:0]  in_weight, out_data;
  logic              in_valid, in_ready, out_valid, out_ready, done;

  int checks = 0, failures = 0;

  typedef struct {
    string            name;
    logic [15:0]      b0, b1;
    logic [3:0][15:0] act, w0, w1;
    logic [15:0]      e0, e1;
    bit               do_bias, gaps, spulse;
    int               bp;
  } vec_t;

  vec_t tbl [4];

  fc_layer_engine #(.DATA_W(DW), .FRAC_W(FW), .IN_LEN(IL), .OUT_CH(OC)) dut (
    .clk(clk), .rst(rst), .bias_valid(bias_valid), .bias_data(bias_data),
    .bias_ready(bias_ready), .bias_loaded(bias_loaded), .start(start), .busy(busy),
    .in_valid(in_valid), .in_data(in_data), .in_weight(in_weight), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Dense-layer arithmetic straight from the number format definition.
  function automatic logic [15:0] ref_lane(input logic [15:0] b, input logic [3:0][15:0] a,
                                           input logic [3:0][15:0] w);
    longint acc, r;
    acc = longint'($signed(b)) * 256;
    for (int i = 0; i < IL; i++) acc += longint'($signed(a[i])) * longint'($signed(w[i]));
    r = acc >>> FW;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`ifdef FC_RELU_EN
    if (r < 0) r = 0;
`endif
    return r[15:0];
  endfunction

  task automatic reset_vals(input string tag);
    chk({tag, "_bias_ready"}, bias_ready, 1);
    chk({tag, "_bias_loaded"}, bias_loaded, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic load_bias(input logic [15:0] b0, input logic [15:0] b1);
    int n;
    for (int k = 0; k < 2; k++) begin
      bias_valid = 1'b1;
      bias_data  = (k == 0) ? b0 : b1;
      #1;
      n = 0;
      while (!bias_ready && n < 20) begin step; n++; end
      chk("bias_ready_wait", bias_ready, 1);
      step;
      if (k == 0) chk("bias_loaded_after_first", bias_loaded, 0);
    end
    bias_valid = 1'b0;
    chk("bias_loaded_after_last", bias_loaded, 1);
  endtask

  task automatic run_frame(input vec_t v, output logic [31:0] res);
    int n;
    logic [31:0] held;
    start = 1'b1;
    #1;
    chk("bias_ready_in_start_cycle", bias_ready, 0);
    step;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_after_start", in_ready, 1);
    if (v.spulse) out_ready = 1'b1;
    for (int i = 0; i < IL; i++) begin
      if (v.gaps) begin
        repeat ($urandom_range(0, 3)) begin
          in_valid = 1'b0;
          start    = v.spulse;
          step;
          start    = 1'b0;
        end
      end
      in_valid  = 1'b1;
      in_data   = v.act[i];
      in_weight = {v.w1[i], v.w0[i]};
      n = 0;
      while (!in_ready && n < 20) begin step; n++; end
      chk("in_ready_wait", in_ready, 1);
      step;
    end
    in_valid = 1'b0;
    chk("in_ready_drain", in_ready, 0);
    chk("out_valid_u1", out_valid, 0);
    step;
    chk("out_valid_u2", out_valid, 0);
    step;
    chk("out_valid_u3", out_valid, 1);
    out_ready = 1'b0;
    held = out_data;
    for (int k = 0; k < v.bp; k++) begin
      start = v.spulse;
      step;
      start = 1'b0;
      chk("out_valid_held", out_valid, 1);
      chk("out_data_stable", out_data, held);
    end
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("out_valid_after_hs", out_valid, 0);
    chk("busy_after_hs", busy, 0);
    step;
    chk("done_single", done, 0);
    res = held;
  endtask

  task automatic check_res(input string tag, input logic [31:0] r,
                           input logic [15:0] e0, input logic [15:0] e1);
    chk({tag, "_ch0"}, {16'h0, r[15:0]}, {16'h0, e0});
    chk({tag, "_ch1"}, {16'h0, r[31:16]}, {16'h0, e1});
  endtask

  initial begin
    logic [31:0] r;
    vec_t v;
    bias_valid = 0; bias_data = 0; start = 0; in_valid = 0; in_data = 0;
    in_weight = 0; out_ready = 0;

    repeat (2) @(posedge clk);
    #1;
    reset_vals("reset");
    @(negedge clk);
    rst = 1'b1;
    step;

    tbl[0] = '{name:"basic", b0:16'h0100, b1:16'hFF00, act:{4{16'h0100}},
               w0:{4{16'h0080}}, w1:{4{16'h0200}}, e0:16'h0300, e1:16'h0700,
               do_bias:1, gaps:0, spulse:0, bp:0};
    tbl[1] = '{name:"saturate", b0:16'h0000, b1:16'h0000, act:{4{16'h7FFF}},
               w0:{4{16'h7FFF}}, w1:{4{16'h8001}}, e0:16'h7FFF,
`ifdef FC_RELU_EN
               e1:16'h0000,
`else
               e1:16'h8000,
`endif
               do_bias:1, gaps:0, spulse:0, bp:0};
    tbl[2] = tbl[0];
    tbl[2].name = "backpressure"; tbl[2].gaps = 1; tbl[2].spulse = 1; tbl[2].bp = 5;
    tbl[3] = tbl[0];
    tbl[3].name = "back_to_back"; tbl[3].do_bias = 0;

    for (int k = 0; k < 4; k++) begin
      if (tbl[k].do_bias) load_bias(tbl[k].b0, tbl[k].b1);
      run_frame(tbl[k], r);
      check_res(tbl[k].name, r, tbl[k].e0, tbl[k].e1);
    end

    // Start with a half-filled bias bank must be ignored.
    rst = 1'b0;
    #2;
    rst = 1'b1;
    step;
    bias_valid = 1'b1; bias_data = 16'h0100;
    step;
    bias_valid = 1'b0; start = 1'b1;
    repeat (3) begin
      step;
      chk("partial_bias_busy", busy, 0);
      chk("partial_bias_in_ready", in_ready, 0);
    end
    start = 1'b0;
    bias_valid = 1'b1; bias_data = 16'hFF00;
    #1;
    chk("partial_bias_ready", bias_ready, 1);
    step;
    bias_valid = 1'b0;
    chk("partial_bias_loaded", bias_loaded, 1);
    run_frame(tbl[0], r);
    check_res("partial_then_full", r, 16'h0300, 16'h0700);

    // Asynchronous reset after two beats, then a reload is required.
    load_bias(16'h0100, 16'hFF00);
    start = 1'b1;
    step;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 16'h0100; in_weight = {16'h0200, 16'h0080};
      step;
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    reset_vals("mid_run_reset");
    @(negedge clk);
    rst = 1'b1;
    step;
    start = 1'b1;
    step;
    start = 1'b0;
    chk("no_start_after_reset", busy, 0);
    v = tbl[0];
    v.b0 = 16'h0200; v.b1 = 16'h0000;
    load_bias(v.b0, v.b1);
    run_frame(v, r);
    check_res("reload", r, 16'h0400, 16'h0800);

    // Random frames against the model.
    for (int j = 0; j < 20; j++) begin
      v = tbl[0];
      v.name = "random"; v.gaps = 1; v.spulse = 0; v.bp = $urandom_range(0, 3);
      if (j % 2 == 0) begin
        v.b0 = 16'($urandom); v.b1 = 16'($urandom);
        for (int i = 0; i < IL; i++) begin
          v.act[i] = 16'($urandom); v.w0[i] = 16'($urandom); v.w1[i] = 16'($urandom);
        end
      end else begin
        v.b0 = 16'($urandom_range(0, 2047)) - 16'd1024;
        v.b1 = 16'($urandom_range(0, 2047)) - 16'd1024;
        for (int i = 0; i < IL; i++) begin
          v.act[i] = 16'($urandom_range(0, 1023)) - 16'd512;
          v.w0[i]  = 16'($urandom_range(0, 1023)) - 16'd512;
          v.w1[i]  = 16'($urandom_range(0, 1023)) - 16'd512;
        end
      end
      load_bias(v.b0, v.b1);
      run_frame(v, r);
      check_res("random", r, ref_lane(v.b0, v.act, v.w0), ref_lane(v.b1, v.act, v.w1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fc_layer_engine.md
# fc_layer_engine

- Parametrised fully-connected (dense) layer engine for the CNN accelerator. It is the generalised successor of the fixed 10-channel final FC layer.
- It holds a per-channel bias bank and consumes a stream of input activations, each paired with a vector of per-channel weights. OUT_CH multiply-accumulate lanes run in parallel.
- When a frame completes, it returns one saturated fixed-point result per channel through a valid/ready handshake.
- It sits between the pixel/weight buffers and the result store.

## Interface
- DATA_W, 16: word width of activations, weights, biases and results (signed, two's complement).
- FRAC_W, 8: fractional bits of the fixed-point format.
- IN_LEN, 25: input beats per frame (flattened input length), ≥1.
- OUT_CH, 10: output channels / MAC lanes, ≥1.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset. Asynchronous and active-low: low forces reset immediately, released synchronously to clk.
- bias_valid  in  1  bias word offered.
- bias_data  in  DATA_W  bias word.
- bias_ready  out  1  bias word accepted when bias_valid&&bias_ready.
- bias_loaded  out  1  full bias bank present.
- start  in  1  request one frame.
- busy  out  1  frame in progress (RUN, DRAIN or OUT).
- in_valid  in  1  activation/weight beat offered.
- in_data  in  DATA_W  activation.
- in_weight  in  OUT_CH*DATA_W  weights; lane c at bits [c*DATA_W +: DATA_W].
- in_ready  out  1  beat accepted when in_valid&&in_ready.
- out_valid  out  1  results valid.
- out_data  out  OUT_CH*DATA_W  results, lane packing as in_weight.
- out_ready  in  1  results consumed when out_valid&&out_ready.
- done  out  1  one-cycle pulse on the result handshake.

## Operation
- States are IDLE, RUN, DRAIN and OUT.
- Bias loading:
  - bias_ready = (state==IDLE) && !start.
  - Accepted words fill channels 0..OUT_CH-1 in order.
  - bias_loaded rises in the cycle after the OUT_CH-th word is accepted.
  - Accepting a word while bias_loaded=1 starts a reload: that word goes to channel 0, bias_loaded clears, and OUT_CH words are needed again.
- Bias persistence: the bank is retained across frames until reset or reload.
- IDLE→RUN: on start && bias_loaded.
  - Each accumulator loads sign-extended bias<<FRAC_W.
  - The beat counter clears.
  - start with bias_loaded=0 is ignored. start outside IDLE is ignored.
- RUN:
  - in_ready=1 while beat count < IN_LEN.
  - Each accepted beat registers OUT_CH products in_data*weight_c. Each product is 2*DATA_W signed.
  - The following cycle adds the registered products into the accumulators.
  - Gaps in in_valid stall with no effect.
  - After beat IN_LEN is accepted: in_ready=0, go to DRAIN.
- DRAIN: the last product is added; go to OUT.
- OUT:
  - Per lane result = acc >>> FRAC_W (arithmetic; truncation toward −∞).
  - Results are saturated to [−2^(DATA_W−1), 2^(DATA_W−1)−1] and registered into out_data.
  - out_valid=1 and out_data are held stable until out_ready.
  - On handshake: done=1 for one cycle, go to IDLE.
- Accumulator width is ACC_W = 2*DATA_W + $clog2(IN_LEN) + 1. No accumulator overflow is possible.

## Timing
- Reset values:
  - state=IDLE; all counters 0.
  - bias_loaded=0; bias bank and accumulators 0.
  - bias_ready=1 while start=0.
  - busy=0, in_ready=0, out_valid=0, out_data=0, done=0.
- Frame latency:
  - start accepted in cycle t → in_ready=1 from t+1.
  - Last beat accepted in cycle u → out_valid=1 at u+3 (product reg at u+1, accumulate at u+2, result reg at u+3).
- busy rises the cycle after start is accepted. It falls the cycle after the out handshake.
- out_ready high before out_valid has no effect.
- out_valid&&out_ready in the same cycle completes the frame with no bubble. start can be accepted on the next cycle.
- Asynchronous reset in any state:
  - The frame is aborted, the bias bank is cleared, and out_valid drops immediately.
  - Partial results are never emitted.

## Configuration
- FC_RELU_EN defined: after saturation, negative lane results are forced to 0 (ReLU fused).
- Undefined: signed saturated results are output unchanged.

## Structure
- Package fc_pkg holds:
  - the state enum type;
  - ACC_W derivation;
  - the saturate/shift function.
- Sub-module fc_mac_lane holds one lane: product register, accumulator, bias load and result register. It is instantiated OUT_CH times in a generate loop.
- The top level holds the FSM, beat counter and bias write pointer.

## Test plan
All scenarios use DATA_W=16, FRAC_W=8, IN_LEN=4, OUT_CH=2.
1. Basic frame:
   - Biases 0x0100, 0xFF00; 4 beats in_data=0x0100 with weights ch0=0x0080, ch1=0x0200.
   - Required: out_data ch0=0x0300, ch1=0x0700; out_valid 3 cycles after the 4th beat.
2. Saturation:
   - in_data=0x7FFF; weights 0x7FFF and 0x8001; bias 0.
   - Required: ch0=0x7FFF.
   - ch1=0x8000 without FC_RELU_EN; 0x0000 with it.
3. Backpressure:
   - Random in_valid gaps; out_ready low for 5 cycles.
   - Required: result identical to scenario 1; out_data stable; start pulses ignored; done is a single pulse.
4. Start without a full bias bank:
   - start after only 1 bias word.
   - Required: busy stays 0, in_ready stays 0. After the 2nd word, bias_loaded=1 and start is accepted.
5. Reset and reload:
   - Reset asserted mid-RUN after 2 beats.
   - Required: all outputs at reset values immediately; bias_loaded=0; the next frame needs a bias reload.
   - Bias reload of 0x0200, 0x0000, then the scenario 1 inputs → 0x0400, 0x0800.
6. Back-to-back frames:
   - start asserted in the cycle after done, bias kept.
   - Required: identical results; bias_ready=0 in the start cycle.
